mem_apb_ws: RTL and testbench

- Parametrised APB slave memory, the next generation of the team's APB memory slave.
- Generalised to configurable data width (32/64), depth and wait-state count.
- Adds AMBA4 byte strobes, PSLVERR on out-of-range or misaligned access, and optional PPROT-based access protection.
- Sits behind the APB master BFM / bridge as one of P_NUM slaves sharing PADDR/PWDATA, with a private PSEL.

---
 rtl/mem_apb_ws_pkg.sv | 25 ++
 rtl/mem_apb_ws_if.sv | 27 ++
 rtl/mem_apb_ram.sv | 30 +++
 rtl/mem_apb_ws.sv | 151 +++++++++++++++
 tb/tb_mem_apb_ws.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_apb_ws_pkg.sv
// Shared definitions for the APB memory slave: FSM state encoding, wait
// counter width and small elaboration-time helpers.
package mem_apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CNT_W = 8;

  // ceil(log2(v)); constant function used for parameter derivation
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_apb_ws_if.sv
// APB (AMBA4) bus bundle for one slave.
//   master: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT
//   slave : drives PRDATA/PREADY/PSLVERR
interface mem_apb_ws_if #(
  parameter int DW = 32
);
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [31:0]     PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]      PPROT;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/mem_apb_ram.sv
// Single-port byte-enable RAM, 2**AW words of DW bits, synchronous read.
//   clk   : clock
//   addr  : word address (read and write)
//   we/be : write enable and per-byte lane enables
//   wdata : write data
//   rdata : registered read data of mem[addr]
module mem_apb_ram
  import mem_apb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr,
  input  logic                 we,
  input  logic [lanes(DW)-1:0] be,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata
);
  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < lanes(DW); b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_apb_ws.sv
// APB slave memory with configurable width, depth and wait states.
// Byte strobes, PSLVERR on out-of-range / misaligned / protected access.
//   PCLK   : bus clock, rising edge
//   PRESET : synchronous active-high reset (memory contents kept)
//   bus    : APB slave modport (PSEL..PPROT in, PRDATA/PREADY/PSLVERR out)
module mem_apb_ws
  import mem_apb_pkg::*;
#(
  parameter int P_DATA_WIDTH    = 32,
  parameter int P_SIZE_IN_BYTES = 1024,
  parameter int P_DELAY         = 0,
  parameter int P_PROT_CHECK    = 0
) (
  input  logic         PCLK,
  input  logic         PRESET,
  mem_apb_ws_if.slave  bus
);
  localparam int NB  = lanes(P_DATA_WIDTH);
  localparam int LB  = clog2(NB);
  localparam int AW  = clog2(P_SIZE_IN_BYTES);
  localparam int WAW = (AW - LB < 1) ? 1 : AW - LB;

  if (P_DATA_WIDTH != 32 && P_DATA_WIDTH != 64) begin : g_bad_dw
    $error("mem_apb_ws: P_DATA_WIDTH must be 32 or 64");
  end
  if (P_DELAY < 0 || P_DELAY > 255) begin : g_bad_delay
    $error("mem_apb_ws: P_DELAY must be 0..255");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WAW-1:0]   waddr_q, waddr_d;
  logic             err_q, err_d;
  logic             write_q, write_d;
  logic             rd_vld_q, rd_vld_d;   // PRDATA shows RAM output only for good reads
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;

  logic                    setup, addr_err, prot_err, ram_we;
  logic [WAW-1:0]          ram_addr;
  logic [P_DATA_WIDTH-1:0] ram_rdata;
  logic                    unused_prot;

  assign unused_prot = ^{bus.PPROT[2], bus.PPROT[0]};

  assign setup    = bus.PSEL && !bus.PENABLE;
  assign prot_err = (P_PROT_CHECK != 0) && bus.PWRITE && bus.PPROT[1] && bus.PADDR[AW-1];
  assign addr_err = (bus.PADDR >= 32'(P_SIZE_IN_BYTES)) || (|bus.PADDR[LB-1:0]) || prot_err;

  // In IDLE the RAM looks at the live bus address so the setup edge
  // registers read data; afterwards it keeps re-reading the captured word.
  assign ram_addr = (state_q == IDLE) ? bus.PADDR[LB +: WAW] : waddr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    err_d     = err_q;
    write_d   = write_q;
    rd_vld_d  = rd_vld_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    ram_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // PENABLE without a setup phase falls through here and is ignored
        if (setup) begin
          waddr_d  = bus.PADDR[LB +: WAW];
          err_d    = addr_err;
          write_d  = bus.PWRITE;
          rd_vld_d = !bus.PWRITE && !addr_err;
          cnt_d    = CNT_W'(P_DELAY);
          if (P_DELAY == 0) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = addr_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.PSEL) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rd_vld_d = 1'b0;
        end else if (bus.PENABLE) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
      DONE: begin
        if (!bus.PSEL || bus.PENABLE) begin
          // completion commits the write; a dropped PSEL aborts it
          ram_we    = bus.PSEL && write_q && !err_q;
          state_d   = IDLE;
          cnt_d     = '0;
          rd_vld_d  = 1'b0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        rd_vld_d  = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      waddr_q   <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      waddr_q   <= waddr_d;
      err_q     <= err_d;
      write_q   <= write_d;
      rd_vld_q  <= rd_vld_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  mem_apb_ram #(.DW(P_DATA_WIDTH), .AW(WAW)) u_ram (
    .clk   (PCLK),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (bus.PSTRB),
    .wdata (bus.PWDATA),
    .rdata (ram_rdata)
  );

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = rd_vld_q ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_apb_ws.sv
// Three slaves share PADDR/PWDATA with private PSEL:
//   0: P_DELAY=0, P_PROT_CHECK=1   1: P_DELAY=3   2: P_DELAY=4
module tb_mem_apb_ws;
  logic        clk = 1'b0;
  logic        prst;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [2:0]  rdy, serr;
  logic [31:0] rdat [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_apb_ws_if #(.DW(32)) bus [3] ();

  for (genvar i = 0; i < 3; i++) begin : g_bus
    assign bus[i].PSEL    = psel[i];
    assign bus[i].PENABLE = penable;
    assign bus[i].PWRITE  = pwrite;
    assign bus[i].PADDR   = paddr;
    assign bus[i].PWDATA  = pwdata;
    assign bus[i].PSTRB   = pstrb;
    assign bus[i].PPROT   = pprot;
    assign rdy[i]  = bus[i].PREADY;
    assign serr[i] = bus[i].PSLVERR;
    assign rdat[i] = bus[i].PRDATA;
  end

  mem_apb_ws #(.P_DATA_WIDTH(32), .P_SIZE_IN_BYTES(1024), .P_DELAY(0), .P_PROT_CHECK(1))
    dut0 (.PCLK(clk), .PRESET(prst), .bus(bus[0]));
  mem_apb_ws #(.P_DATA_WIDTH(32), .P_SIZE_IN_BYTES(1024), .P_DELAY(3), .P_PROT_CHECK(0))
    dut1 (.PCLK(clk), .PRESET(prst), .bus(bus[1]));
  mem_apb_ws #(.P_DATA_WIDTH(32), .P_SIZE_IN_BYTES(1024), .P_DELAY(4), .P_PROT_CHECK(0))
    dut2 (.PCLK(clk), .PRESET(prst), .bus(bus[2]));

  task automatic idle_bus();
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0;
  endtask

  // One complete APB transfer; returns data/error at PREADY, number of
  // access cycles with PREADY low, and PREADY just after the completion edge.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int w, output logic rdy_after);
    psel = '0; psel[s] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = st; pprot = pr;
    @(posedge clk); #1;
    penable = 1'b1;
    w = 0;
    while (!rdy[s] && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!rdy[s]) begin
      errors++;
      $display("FAIL xfer_timeout slave=%0d addr=%h: PREADY=%b, required 1", s, a, rdy[s]);
    end
    rd = rdat[s]; er = serr[s];
    @(posedge clk); #1;
    rdy_after = rdy[s];
    psel = '0; penable = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    prst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rdy[s] !== 1'b0 || serr[s] !== 1'b0 || rdat[s] !== 32'h0) begin
        errors++;
        $display("FAIL reset slave=%0d: PREADY=%b PSLVERR=%b PRDATA=%h, required 0 0 0",
                 s, rdy[s], serr[s], rdat[s]);
      end
    end
    prst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er, ra; int w;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b0 || w != 0) begin
      errors++; $display("FAIL zw_write: err=%b waits=%0d, required 0 0", er, w);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || w != 0) begin
      errors++;
      $display("FAIL zw_read: data=%h err=%b waits=%0d, required deadbeef 0 0", rd, er, w);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er, ra; int w;
    xfer(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b0 || w != 3) begin
      errors++; $display("FAIL ws_write: err=%b waits=%0d, required 0 3", er, w);
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'h12345678 || er !== 1'b0 || w != 3) begin
      errors++;
      $display("FAIL ws_read: data=%h err=%b waits=%0d, required 12345678 0 3", rd, er, w);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic er, ra; int w;
    xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, w, ra);
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'b0101, 3'b000, rd, er, w, ra);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hFF22FF44) begin
      errors++; $display("FAIL strobe_0101: data=%h, required ff22ff44", rd);
    end
    xfer(0, 1'b1, 32'h0, 32'h00000000, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL strobe_zero_err: err=%b, required 0", er);
    end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hFF22FF44) begin
      errors++; $display("FAIL strobe_zero_data: data=%h, required ff22ff44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, ra; int w;
    xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_range_read: err=%b data=%h, required 1 00000000", er, rd);
    end
    xfer(0, 1'b1, 32'h13, 32'hCAFEBABE, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_misaligned_write: err=%b, required 1", er);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL err_mem_unchanged: data=%h err=%b, required deadbeef 0", rd, er);
    end
    xfer(1, 1'b0, 32'h1000_0020, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || w != 3) begin
      errors++;
      $display("FAIL err_high_addr: err=%b data=%h waits=%0d, required 1 00000000 3", er, rd, w);
    end
  endtask

  task automatic test_prot();
    logic [31:0] rd; logic er, ra; int w;
    xfer(0, 1'b1, 32'h300, 32'h5A5A5A5A, 4'hF, 3'b000, rd, er, w, ra);
    xfer(0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'hF, 3'b010, rd, er, w, ra);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL prot_nonsecure_err: err=%b, required 1", er);
    end
    xfer(0, 1'b0, 32'h300, 32'h0, 4'h0, 3'b010, rd, er, w, ra);
    checks++;
    if (rd !== 32'h5A5A5A5A || er !== 1'b0) begin
      errors++; $display("FAIL prot_no_write: data=%h err=%b, required 5a5a5a5a 0", rd, er);
    end
    xfer(0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL prot_secure_err: err=%b, required 0", er);
    end
    xfer(0, 1'b0, 32'h300, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL prot_readback: data=%h, required a5a5a5a5", rd);
    end
    xfer(0, 1'b1, 32'h100, 32'h0BADF00D, 4'hF, 3'b010, rd, er, w, ra);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL prot_lower_half: err=%b, required 0", er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, ra; int w;
    xfer(0, 1'b1, 32'h80, 32'hAABBCCDD, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (ra !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_drop: PREADY=%b after completion, required 0", ra);
    end
    xfer(0, 1'b1, 32'h84, 32'h01234567, 4'hF, 3'b000, rd, er, w, ra);
    xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hAABBCCDD || w != 0) begin
      errors++; $display("FAIL b2b_read0: data=%h waits=%0d, required aabbccdd 0", rd, w);
    end
    xfer(0, 1'b0, 32'h84, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'h01234567) begin
      errors++; $display("FAIL b2b_read1: data=%h, required 01234567", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er, ra; int w;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'hBAD0BAD0; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (rdy[1] !== 1'b0) begin
        errors++; $display("FAIL abort_ready: PREADY=%b, required 0", rdy[1]);
      end
    end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL abort_no_write: data=%h, required 12345678", rd);
    end
  endtask

  task automatic test_violation();
    logic [31:0] rd; logic er, ra; int w;
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (rdy[0] !== 1'b0) begin
        errors++; $display("FAIL violation_ready: PREADY=%b, required 0", rdy[0]);
      end
    end
    idle_bus();
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL violation_no_write: data=%h, required deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, ra; int w;
    xfer(2, 1'b1, 32'h40, 32'h01020304, 4'hF, 3'b000, rd, er, w, ra);
    checks++;
    if (w != 4) begin
      errors++; $display("FAIL rm_waits: waits=%0d, required 4", w);
    end
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;               // first wait cycle
    @(posedge clk); #1;
    prst = 1'b1;                  // second wait cycle
    @(posedge clk); #1;
    checks++;
    if (rdy[2] !== 1'b0 || serr[2] !== 1'b0 || rdat[2] !== 32'h0) begin
      errors++;
      $display("FAIL rm_outputs: PREADY=%b PSLVERR=%b PRDATA=%h, required 0 0 0",
               rdy[2], serr[2], rdat[2]);
    end
    prst = 1'b0;
    // bus left in access phase: without a fresh setup it must stay idle
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (rdy[2] !== 1'b0) begin
        errors++; $display("FAIL rm_stay_idle: PREADY=%b, required 0", rdy[2]);
      end
    end
    idle_bus();
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, w, ra);
    checks++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      errors++; $display("FAIL rm_prior_value: data=%h err=%b, required 01020304 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_strobe();
    test_errors();
    test_prot();
    test_back_to_back();
    test_abort();
    test_violation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
